// File: rtl/spi_unit_dispatcher.sv
// spi_unit_dispatcher: serialises one execute-unit request as an SPI frame and returns the 16-bit result
module spi_unit_dispatcher #(
    parameter int CLK_DIV = 2,
    parameter int N_UNITS = 3,
    parameter int GAP_CYC = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_unit,
    input  logic [3:0]         req_op,
    input  logic [15:0]        req_a,
    input  logic [15:0]        req_b,
    output logic               rsp_valid,
    output logic [15:0]        rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               sclk,
    output logic               mosi,
    output logic [N_UNITS-1:0] cs_n,
    input  logic [N_UNITS-1:0] miso
);
    typedef enum logic [2:0] {IDLE, ERR, TX, RX, DONE, GAP} state_t;
    localparam int DW = $clog2(2 * CLK_DIV + 1);
    localparam int GW = $clog2(GAP_CYC + 2);
    state_t        state;
    logic [35:0]   sr;
    logic [15:0]   rx;
    logic [5:0]    bit_cnt;
    logic [DW-1:0] div;
    logic [GW-1:0] gap_cnt;
    logic          miso_sel;
    logic          bit_end;
    assign miso_sel = |(miso & ~cs_n);
    assign bit_end  = div == DW'(2 * CLK_DIV - 1);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            cs_n      <= '1;
            sr        <= '0;
            rx        <= '0;
            bit_cnt   <= '0;
            div       <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    sr        <= {req_op, req_a, req_b};
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    div       <= '0;
                    bit_cnt   <= '0;
                    sclk      <= 1'b0;
                    if (int'(req_unit) >= N_UNITS) begin
                        state     <= ERR;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                    end else begin
                        state <= TX;
                        mosi  <= req_op[3];
                        cs_n  <= ~(N_UNITS'(1) << req_unit);
                    end
                end
                TX, RX: begin
                    // Bit boundary: drop sclk and present the next mosi bit (zeros once sr drains)
                    if (bit_end) begin
                        div     <= '0;
                        sclk    <= 1'b0;
                        bit_cnt <= bit_cnt + 6'd1;
                        sr      <= sr << 1;
                        mosi    <= sr[34];
                        if (bit_cnt == 6'd35) state <= RX;
                        if (bit_cnt == 6'd51) begin
                            state     <= DONE;
                            cs_n      <= '1;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= rx;
                        end
                    end else begin
                        div <= div + DW'(1);
                        if (div == DW'(CLK_DIV - 1)) begin
                            sclk <= 1'b1;
                            rx   <= {rx[14:0], miso_sel};
                        end
                    end
                end
                DONE, ERR: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    if (GAP_CYC == 0) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                end
                GAP: if (gap_cnt == GW'(GAP_CYC - 1)) begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
